dm_block_copier: RTL and testbench

Bus-initiator engine that drives the data-memory port (address, write data, write enable, read enable) and consumes its read data. Software-side control logic loads a source address, destination address, and word count, then pulses a start strobe. The engine copies the region word by word, or fills the destination with a constant, and reports completion. It sits beside the CPU datapath and takes over the data-memory port while busy; the external arbiter muxes the port on `Busy`.

---
 rtl/dm_block_copier.sv | 156 +++++++++++++++
 tb/tb_dm_block_copier.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dm_block_copier.sv
// dm_block_copier: block copy / constant fill engine that owns the
// data-memory port while Busy. It copies one word per RD+WR pair, or fills
// one word per WR cycle, in strictly ascending address order.
module dm_block_copier #(
  parameter int AW = 24,
  parameter int DW = 24,
  parameter int CW = 24
) (
  input  logic          Clock,
  input  logic          ResetN,
  input  logic          Start,
  input  logic          Abort,
  input  logic          Mode,
  input  logic [AW-1:0] SrcAddr,
  input  logic [AW-1:0] DstAddr,
  input  logic [CW-1:0] Count,
  input  logic [DW-1:0] FillData,
  output logic [AW-1:0] Adresa,
  output logic [DW-1:0] WriteData,
  output logic          MemWrite,
  output logic          MemRead,
  input  logic [DW-1:0] ReadData,
  output logic          Busy,
  output logic          Done,
  output logic [CW-1:0] WordsDone
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    FIN  = 2'd3
  } state_t;

  state_t        state_reg;
  logic          mode_reg;     // 0 = copy, 1 = fill
  logic [AW-1:0] src_ptr_reg;  // address of the next word to read
  logic [AW-1:0] dst_ptr_reg;  // address of the next word to write
  logic [CW-1:0] count_reg;
  logic [DW-1:0] fill_reg;

  logic [CW-1:0] words_next;
  logic          last_word;
  logic [AW-1:0] src_ptr_next;
  logic [AW-1:0] dst_ptr_next;

  // Pointer / counter increments; address arithmetic wraps modulo 2^AW
  always_comb begin
    words_next   = WordsDone + CW'(1);
    last_word    = (words_next == count_reg);
    src_ptr_next = src_ptr_reg + AW'(1);
    dst_ptr_next = dst_ptr_reg + AW'(1);
  end

  // Transfer sequencer. Every port output is a register; the values written
  // on a transition are the ones the memory sees during the state entered.
  // WriteData doubles as the word buffer between RD and WR.
  always_ff @(posedge Clock) begin
    if (!ResetN) begin
      state_reg   <= IDLE;
      mode_reg    <= 1'b0;
      src_ptr_reg <= '0;
      dst_ptr_reg <= '0;
      count_reg   <= '0;
      fill_reg    <= '0;
      Adresa      <= '0;
      WriteData   <= '0;
      MemWrite    <= 1'b0;
      MemRead     <= 1'b0;
      Busy        <= 1'b0;
      Done        <= 1'b0;
      WordsDone   <= '0;
    end else begin
      Done <= 1'b0;
      case (state_reg)
        IDLE: begin
          // Abort beats Start, so a simultaneous pair is simply dropped
          if (Start && !Abort) begin
            mode_reg    <= Mode;
            src_ptr_reg <= SrcAddr;
            dst_ptr_reg <= DstAddr;
            count_reg   <= Count;
            fill_reg    <= FillData;
            WordsDone   <= '0;
            if (Count == '0) begin
              // Empty transfer: straight to completion, no memory access
              state_reg <= FIN;
              Done      <= 1'b1;
            end else if (Mode) begin
              state_reg <= WR;
              Adresa    <= DstAddr;
              WriteData <= FillData;
              MemWrite  <= 1'b1;
              Busy      <= 1'b1;
            end else begin
              state_reg <= RD;
              Adresa    <= SrcAddr;
              MemRead   <= 1'b1;
              Busy      <= 1'b1;
            end
          end
        end

        RD: begin
          if (Abort) begin
            state_reg <= IDLE;
            MemRead   <= 1'b0;
            Busy      <= 1'b0;
          end else begin
            // Read data is combinational from memory; capture it so it is
            // presented as write data in the very next cycle
            state_reg   <= WR;
            WriteData   <= ReadData;
            Adresa      <= dst_ptr_reg;
            src_ptr_reg <= src_ptr_next;
            MemRead     <= 1'b0;
            MemWrite    <= 1'b1;
          end
        end

        WR: begin
          // The write of this cycle lands on this edge even when aborting
          WordsDone   <= words_next;
          dst_ptr_reg <= dst_ptr_next;
          if (Abort) begin
            state_reg <= IDLE;
            MemWrite  <= 1'b0;
            Busy      <= 1'b0;
          end else if (last_word) begin
            state_reg <= FIN;
            MemWrite  <= 1'b0;
            Busy      <= 1'b0;
            Done      <= 1'b1;
          end else if (mode_reg) begin
            Adresa    <= dst_ptr_next;
            WriteData <= fill_reg;
          end else begin
            state_reg <= RD;
            Adresa    <= src_ptr_reg;
            MemWrite  <= 1'b0;
            MemRead   <= 1'b1;
          end
        end

        FIN: begin
          state_reg <= IDLE;
        end

        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dm_block_copier.sv
// Scoreboard bench for dm_block_copier: a transfer-level reference model
// pushes expected reads, writes and completions; a negedge monitor pops and
// compares whenever the engine drives the memory port or pulses Done.
module tb_dm_block_copier;
  localparam int AW = 24;
  localparam int DW = 24;
  localparam int CW = 24;

  logic          Clock;
  logic          ResetN;
  logic          Start;
  logic          Abort;
  logic          Mode;
  logic [AW-1:0] SrcAddr;
  logic [AW-1:0] DstAddr;
  logic [CW-1:0] Count;
  logic [DW-1:0] FillData;
  logic [AW-1:0] Adresa;
  logic [DW-1:0] WriteData;
  logic          MemWrite;
  logic          MemRead;
  logic [DW-1:0] ReadData;
  logic          Busy;
  logic          Done;
  logic [CW-1:0] WordsDone;

  dm_block_copier #(.AW(AW), .DW(DW), .CW(CW)) dut (
    .Clock(Clock), .ResetN(ResetN), .Start(Start), .Abort(Abort), .Mode(Mode),
    .SrcAddr(SrcAddr), .DstAddr(DstAddr), .Count(Count), .FillData(FillData),
    .Adresa(Adresa), .WriteData(WriteData), .MemWrite(MemWrite), .MemRead(MemRead),
    .ReadData(ReadData), .Busy(Busy), .Done(Done), .WordsDone(WordsDone)
  );

  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    int            idx;
  } wr_t;

  typedef struct {
    int cyc;
    int words;
  } done_t;

  wr_t           wr_q[$];
  logic [AW-1:0] rd_q[$];
  done_t         done_q[$];

  logic [DW-1:0] mem     [logic [AW-1:0]];  // memory as driven by the DUT
  logic [DW-1:0] ref_mem [logic [AW-1:0]];  // memory as the model predicts

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  function automatic logic [DW-1:0] dflt(input logic [AW-1:0] a);
    return a ^ 24'h5A5A5A;
  endfunction

  function automatic logic [DW-1:0] mem_rd(input logic [AW-1:0] a);
    return mem.exists(a) ? mem[a] : dflt(a);
  endfunction

  function automatic logic [DW-1:0] ref_rd(input logic [AW-1:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name, input logic [31:0] act);
    checks++;
    failures++;
    $display("FAIL %s: got %0h expected no event (cycle %0d)", name, act, cyc);
  endtask

  // Count rising edges so Done timing can be checked against the Start edge
  always @(posedge Clock) cyc <= cyc + 1;

  // Memory: combinational read while MemRead, write committed when MemWrite
  always @(negedge Clock) begin
    if (MemWrite === 1'b1) mem[Adresa] = WriteData;
    ReadData = (MemRead === 1'b1) ? mem_rd(Adresa) : '0;
  end

  // Monitor: pop and compare on every memory access and every Done pulse
  always @(negedge Clock) begin
    wr_t           w;
    done_t         d;
    logic [AW-1:0] ra;
    chk("enable_overlap", {31'b0, MemRead & MemWrite}, 32'd0);
    chk("busy_vs_enables", {31'b0, Busy}, {31'b0, MemRead | MemWrite});
    if (MemRead === 1'b1) begin
      if (rd_q.size() == 0) fail_now("unexpected_read", {8'h0, Adresa});
      else begin
        ra = rd_q.pop_front();
        chk("read_addr", {8'h0, Adresa}, {8'h0, ra});
      end
    end
    if (MemWrite === 1'b1) begin
      if (wr_q.size() == 0) fail_now("unexpected_write", {8'h0, Adresa});
      else begin
        w = wr_q.pop_front();
        chk("write_addr", {8'h0, Adresa}, {8'h0, w.addr});
        chk("write_data", {8'h0, WriteData}, {8'h0, w.data});
        chk("write_words", {8'h0, WordsDone}, w.idx);
      end
    end
    if (Done === 1'b1) begin
      if (done_q.size() == 0) fail_now("unexpected_done", {8'h0, WordsDone});
      else begin
        d = done_q.pop_front();
        chk("done_cycle", cyc, d.cyc);
        chk("done_words", {8'h0, WordsDone}, d.words);
      end
    end
  end

  // Reference: word i reads src+i then writes dst+i, ascending, so a later
  // read sees earlier writes of the same transfer. Only nwr words happen.
  task automatic model_xfer(input bit mode, input logic [AW-1:0] src, input logic [AW-1:0] dst,
                            input int cnt, input logic [DW-1:0] fill, input int nwr,
                            input int c0, input bit with_done);
    logic [AW-1:0] ra;
    logic [AW-1:0] wa;
    logic [DW-1:0] d;
    wr_t           w;
    done_t         dn;
    for (int i = 0; i < nwr; i++) begin
      if (mode) d = fill;
      else begin
        ra = src + AW'(i);
        rd_q.push_back(ra);
        d = ref_rd(ra);
      end
      wa = dst + AW'(i);
      ref_mem[wa] = d;
      w.addr = wa;
      w.data = d;
      w.idx  = i;
      wr_q.push_back(w);
    end
    if (with_done) begin
      dn.cyc   = c0 + (mode ? cnt : 2 * cnt);
      dn.words = cnt;
      done_q.push_back(dn);
    end
  endtask

  // Called at a negedge; Start is sampled at the following rising edge
  task automatic start_xfer(input bit mode, input logic [AW-1:0] src, input logic [AW-1:0] dst,
                            input int cnt, input logic [DW-1:0] fill, input int nwr,
                            input bit with_done);
    Mode = mode;
    SrcAddr = src;
    DstAddr = dst;
    Count = CW'(cnt);
    FillData = fill;
    Start = 1'b1;
    model_xfer(mode, src, dst, cnt, fill, nwr, cyc + 1, with_done);
    $display("xfer mode=%0d src=%06h dst=%06h count=%0d fill=%06h words=%0d",
             mode, src, dst, cnt, fill, nwr);
    @(posedge Clock);
    @(negedge Clock);
    Start = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((rd_q.size() != 0 || wr_q.size() != 0 || done_q.size() != 0 || Busy !== 1'b0) && n < 100) begin
      @(negedge Clock);
      n++;
    end
    checks++;
    if (n >= 100) begin
      failures++;
      $display("FAIL wait_idle: got %0d pending events expected 0", rd_q.size() + wr_q.size() + done_q.size());
      rd_q.delete();
      wr_q.delete();
      done_q.delete();
    end
    @(negedge Clock);
  endtask

  task automatic run_xfer(input bit mode, input logic [AW-1:0] src, input logic [AW-1:0] dst,
                          input int cnt, input logic [DW-1:0] fill);
    start_xfer(mode, src, dst, cnt, fill, cnt, 1'b1);
    wait_idle();
    chk("final_words", {8'h0, WordsDone}, cnt);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_adresa"}, {8'h0, Adresa}, 32'd0);
    chk({tag, "_wdata"}, {8'h0, WriteData}, 32'd0);
    chk({tag, "_memwrite"}, {31'b0, MemWrite}, 32'd0);
    chk({tag, "_memread"}, {31'b0, MemRead}, 32'd0);
    chk({tag, "_busy"}, {31'b0, Busy}, 32'd0);
    chk({tag, "_done"}, {31'b0, Done}, 32'd0);
    chk({tag, "_words"}, {8'h0, WordsDone}, 32'd0);
  endtask

  initial begin
    logic          m;
    int            n;
    logic [AW-1:0] s;
    logic [AW-1:0] d;
    logic [DW-1:0] f;

    ResetN = 1'b0;
    Start = 1'b0;
    Abort = 1'b0;
    Mode = 1'b0;
    SrcAddr = '0;
    DstAddr = '0;
    Count = '0;
    FillData = '0;
    repeat (3) @(negedge Clock);
    check_zero("reset");
    ResetN = 1'b1;
    @(negedge Clock);

    // Copy 2..4 -> 10..12; a Start while busy must be ignored
    mem[24'd2] = 24'd30; mem[24'd3] = 24'd31; mem[24'd4] = 24'd32;
    ref_mem[24'd2] = 24'd30; ref_mem[24'd3] = 24'd31; ref_mem[24'd4] = 24'd32;
    start_xfer(1'b0, 24'd2, 24'd10, 3, 24'd0, 3, 1'b1);
    Mode = 1'b1;
    DstAddr = 24'h40;
    Count = 24'd5;
    Start = 1'b1;
    @(negedge Clock);
    Start = 1'b0;
    wait_idle();
    chk("copy_words", {8'h0, WordsDone}, 32'd3);
    chk("copy_mem10", {8'h0, mem_rd(24'd10)}, 32'd30);
    chk("copy_mem11", {8'h0, mem_rd(24'd11)}, 32'd31);
    chk("copy_mem12", {8'h0, mem_rd(24'd12)}, 32'd32);

    // Fill 5..8 with a constant
    run_xfer(1'b1, 24'd0, 24'd5, 4, 24'hABCDEF);
    for (int i = 5; i <= 8; i++) chk("fill_mem", {8'h0, mem_rd(AW'(i))}, 32'h00ABCDEF);

    // Address wrap on both pointers
    run_xfer(1'b0, 24'hFFFFFE, 24'hFFFFFF, 2, 24'd0);

    // Zero-length transfer
    run_xfer(1'b0, 24'h20, 24'h30, 0, 24'd0);

    // Start together with Abort in IDLE is dropped
    Mode = 1'b1;
    Count = 24'd5;
    DstAddr = 24'h50;
    Start = 1'b1;
    Abort = 1'b1;
    @(negedge Clock);
    Start = 1'b0;
    Abort = 1'b0;
    @(negedge Clock);
    chk("start_abort_busy", {31'b0, Busy}, 32'd0);

    // Abort in the third WR cycle of an 8-word copy
    start_xfer(1'b0, 24'h100, 24'h200, 8, 24'd0, 3, 1'b0);
    repeat (5) @(negedge Clock);
    Abort = 1'b1;
    @(negedge Clock);
    Abort = 1'b0;
    chk("abort_busy", {31'b0, Busy}, 32'd0);
    chk("abort_memwrite", {31'b0, MemWrite}, 32'd0);
    chk("abort_words", {8'h0, WordsDone}, 32'd3);
    chk("abort_untouched", {8'h0, mem_rd(24'h203)}, {8'h0, dflt(24'h203)});
    wait_idle();

    // Reset in the middle of a fill, then a normal transfer
    start_xfer(1'b1, 24'd0, 24'h300, 10, 24'h123456, 4, 1'b0);
    repeat (3) @(negedge Clock);
    ResetN = 1'b0;
    @(negedge Clock);
    check_zero("midreset");
    ResetN = 1'b1;
    run_xfer(1'b1, 24'd0, 24'h310, 2, 24'h654321);

    // Randomised transfers, including overlap and wrap-around regions
    for (int t = 0; t < 24; t++) begin
      m = 1'($urandom_range(0, 1));
      n = int'($urandom_range(0, 6));
      if ($urandom_range(0, 3) == 0) s = 24'hFFFFFA + AW'($urandom_range(0, 5));
      else s = AW'($urandom);
      if ($urandom_range(0, 1) == 0) d = s + AW'($urandom_range(0, 3));
      else d = AW'($urandom);
      f = DW'($urandom);
      run_xfer(m, s, d, n, f);
    end

    // Whole-memory agreement in both directions
    foreach (mem[a]) chk("mem_final", {8'h0, mem[a]}, {8'h0, ref_rd(a)});
    foreach (ref_mem[a]) chk("mem_written", {8'h0, mem_rd(a)}, {8'h0, ref_mem[a]});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
